line_sram_bridge: RTL

Responder end of the 512-bit cache-line external bus driven by icache/dcache. Serves line reads and line writes by sequencing 16 word accesses to a 32-bit synchronous single-port SRAM. It sits beside rom/ram on the shared external bus and is selected by an external chip_select decode. data_o is zero whenever data_ready is low, so its output can be OR-combined with other responders on the shared read bus.

---
 rtl/line_sram_bridge.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/line_sram_bridge.sv
// Cache-line responder: turns one 512-bit line read/write into 16 accesses on a 32-bit sync SRAM.
// Latency: data_ready 17 cycles after acceptance for reads, 16 for writes; critical-word-first reads with LINE_BRIDGE_CWF_EN.
// Backpressure: initiator holds addr_valid until data_ready; bridge waits for addr_valid low before re-arming.
module line_sram_bridge #(
  parameter int ADDR_W     = 14,
  parameter int LINE_WORDS = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              chip_select,
  input  logic              addr_valid,
  input  logic [ADDR_W-1:0] addr,
  input  logic              data_valid,
  input  logic [511:0]      data_i,
  output logic              data_ready,
  output logic [511:0]      data_o,
  output logic              sram_en,
  output logic              sram_we,
  output logic [ADDR_W-3:0] sram_addr,
  output logic [31:0]       sram_wdata,
  input  logic [31:0]       sram_rdata
);

  localparam int IDX_W  = $clog2(LINE_WORDS);
  localparam int LINE_W = ADDR_W - 6;
  localparam logic [IDX_W-1:0] LAST_CNT = IDX_W'(LINE_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_RD_LAST,
    S_WR,
    S_DONE,
    S_RELEASE
  } state_t;

  state_t             state_q, state_nxt;
  logic [LINE_W-1:0]  line_q;
  logic [511:0]       buf_q;
  logic [IDX_W-1:0]   idx_q;
  logic [IDX_W-1:0]   cnt_q;
  logic               cap_vld_q;
  logic [IDX_W-1:0]   cap_idx_q;
  logic               is_wr_q;
  logic               accept;
  logic [IDX_W-1:0]   rd_start;
  logic               unused_addr_lo;

  assign accept = (state_q == S_IDLE) && chip_select && addr_valid;

`ifdef LINE_BRIDGE_CWF_EN
  assign rd_start = addr[5:2];
`else
  assign rd_start = '0;
`endif
  assign unused_addr_lo = ^addr[5:0];

  // One buffer serves both directions: write data is latched here, read words overwrite it slot by slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      line_q    <= '0;
      buf_q     <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      cap_vld_q <= 1'b0;
      cap_idx_q <= '0;
      is_wr_q   <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      cap_vld_q <= (state_q == S_RD);
      cap_idx_q <= idx_q;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            line_q  <= addr[ADDR_W-1:6];
            buf_q   <= data_i;
            is_wr_q <= data_valid;
            cnt_q   <= '0;
            idx_q   <= data_valid ? '0 : rd_start;
          end
        end
        S_RD, S_WR: begin
          idx_q <= idx_q + 1'b1;
          cnt_q <= cnt_q + 1'b1;
        end
        default: ;
      endcase
      // SRAM returns the word one cycle after issue; it lands in its natural slot.
      if (cap_vld_q) begin
        buf_q[32*cap_idx_q +: 32] <= sram_rdata;
      end
    end
  end

  always_comb begin
    state_nxt  = state_q;
    sram_en    = 1'b0;
    sram_we    = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    data_ready = 1'b0;
    data_o     = '0;
    case (state_q)
      S_IDLE: begin
        if (chip_select && addr_valid) begin
          state_nxt = data_valid ? S_WR : S_RD;
        end
      end
      S_RD: begin
        sram_en   = 1'b1;
        sram_addr = {line_q, idx_q};
        if (cnt_q == LAST_CNT) begin
          state_nxt = S_RD_LAST;
        end
      end
      S_RD_LAST: begin
        state_nxt = S_DONE;
      end
      S_WR: begin
        sram_en    = 1'b1;
        sram_we    = 1'b1;
        sram_addr  = {line_q, idx_q};
        sram_wdata = buf_q[32*idx_q +: 32];
        if (cnt_q == LAST_CNT) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        data_ready = 1'b1;
        if (!is_wr_q) begin
          data_o = buf_q;
        end
        state_nxt = S_RELEASE;
      end
      S_RELEASE: begin
        // A request still held from the finished transaction must not be served twice.
        if (!addr_valid) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule
